bus_if: RTL and testbench
=========================

BUS_IF -- requirements
Module: bus_if

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port stall, input, 1 bit: pipeline stall request.
REQ-004 SHALL have port flush, input, 1 bit: pipeline flush; suppresses starting a new access.
REQ-005 SHALL have port busy, output, 1 bit: access in progress; the pipeline must hold.
REQ-006 SHALL have port addr, input, 30 bits: word address from the memory-access stage.
REQ-007 SHALL have port as_, input, 1 bit: access strobe, active-low.
REQ-008 SHALL have port rw, input, 1 bit: direction; 1 = READ, 0 = WRITE.
REQ-009 SHALL have port wr_data, input, 32 bits: store data.
REQ-010 SHALL have port rd_data, output, 32 bits: load data returned to the memory-access stage.
REQ-011 SHALL have port bus_req_, output, 1 bit: bus request, active-low.
REQ-012 SHALL have port bus_grnt_, input, 1 bit: bus grant, active-low.
REQ-013 SHALL have port bus_as_, output, 1 bit: bus address strobe, active-low.
REQ-014 SHALL have port bus_rw, output, 1 bit: bus direction.
REQ-015 SHALL have port bus_addr, output, 30 bits: bus word address.
REQ-016 SHALL have port bus_wr_data, output, 32 bits: bus write data.
REQ-017 SHALL have port bus_rd_data, input, 32 bits: bus read data.
REQ-018 SHALL have port bus_rdy_, input, 1 bit: bus ready, active-low.

Function
REQ-019 SHALL implement a 4-state FSM: IDLE, REQ, ACCESS, WAIT, with a 32-bit read buffer rd_buf.
REQ-020 In IDLE with as_=0 and flush=0, the block SHALL drive bus_req_=0 and busy=1 combinationally, and SHALL go to REQ on the next clock.
REQ-021 In IDLE with as_=1 or flush=1, the block SHALL drive busy=0 and rd_data=rd_buf, and SHALL not start an access.
REQ-022 In REQ, the block SHALL drive busy=1 and keep bus_req_=0.
REQ-023 In REQ with bus_grnt_=0, the block SHALL register bus_as_=0, bus_addr=addr and bus_rw=rw, and SHALL register bus_wr_data=wr_data only if rw=WRITE. The FSM SHALL then go to ACCESS.
REQ-024 Registered bus_as_ SHALL be asserted for exactly one cycle: it is forced to 1 on every clock in which the state is not REQ with a grant.
REQ-025 In ACCESS with bus_rdy_=1, the block SHALL drive busy=1 and hold bus_req_=0, bus_addr, bus_rw and bus_wr_data. Wait states are unbounded.
REQ-026 In ACCESS with bus_rdy_=0, the block SHALL drive busy=0 and rd_data=bus_rd_data in the same cycle.
REQ-027 On that ACCESS cycle with bus_rdy_=0, the block SHALL register bus_req_=1, and SHALL register rd_buf=bus_rd_data if bus_rw=READ.
REQ-028 On that cycle, the next state SHALL be WAIT if stall=1, else IDLE.
REQ-029 In WAIT, the block SHALL drive busy=0 and rd_data=rd_buf.
REQ-030 WAIT SHALL return to IDLE when stall=0, so a stalled pipeline does not reissue the access.
REQ-031 On a write, rd_buf SHALL be unchanged.
REQ-032 flush SHALL affect only IDLE; once in REQ or ACCESS the access SHALL complete.
REQ-033 The block SHALL do no address decode or alignment check; misaligned accesses are filtered upstream.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL force: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=READ(1), bus_addr=0, bus_wr_data=0, rd_buf=0.
REQ-035 Reset SHALL override every other input, including mid-REQ or mid-ACCESS; the aborted access SHALL be dropped with no retry.
REQ-036 After reset with as_=1, busy SHALL be 0 and rd_data SHALL be 0x00000000.

Verification
REQ-037 Read with no wait states: as_=0, rw=1, addr=0x0000100, grant next cycle, bus_rdy_=0 in ACCESS with bus_rd_data=0xDEADBEEF -> bus_as_ low for 1 cycle, bus_addr=0x0000100, rd_data=0xDEADBEEF, busy 1,1,0 across IDLE/REQ/ACCESS.
REQ-038 Write with a delayed grant and 3 wait states: rw=0, wr_data=0x12345678, grant after 2 cycles, bus_rdy_ low on 4th ACCESS cycle -> bus_wr_data=0x12345678 held throughout, busy high until ready, rd_buf unchanged.
REQ-039 Stall at completion: read returns 0xA5A5A5A5 with stall=1 for 3 more cycles -> state WAIT, busy=0, rd_data=0xA5A5A5A5 each cycle, no second bus_req_ until stall=0.
REQ-040 Flush in IDLE: as_=0 with flush=1 -> bus_req_ stays 1, busy=0, state stays IDLE.
REQ-041 Reset during ACCESS: reset=1 while waiting on bus_rdy_ -> next cycle IDLE, bus_req_=1, bus_as_=1, bus_addr=0, rd_data=0.
REQ-042 Back-to-back reads: a second as_=0 in the IDLE cycle right after completion -> a new REQ begins with no extra idle cycle.

Source files
------------

// File: rtl/bus_if.sv
// Memory-stage bus interface: requests the bus, issues a one-cycle address strobe,
// waits for ready and returns load data, holding it in rd_buf while the pipeline stalls.
module bus_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] addr,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic        start_s;
  logic        bus_req_r;
  logic        bus_as_r;
  logic        bus_rw_r;
  logic [29:0] bus_addr_r;
  logic [31:0] bus_wr_data_r;
  logic [31:0] rd_buf_r;

  assign start_s     = (as_ == 1'b0) && (flush == 1'b0);
  assign bus_as_     = bus_as_r;
  assign bus_rw      = bus_rw_r;
  assign bus_addr    = bus_addr_r;
  assign bus_wr_data = bus_wr_data_r;

  // Next-state decode plus the combinational busy / bus_req_ / rd_data outputs.
  always_comb begin
    state_nx_s = state_r;
    busy       = 1'b0;
    rd_data    = rd_buf_r;
    bus_req_   = bus_req_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          bus_req_   = 1'b0;
          busy       = 1'b1;
          state_nx_s = REQ;
        end else begin
          bus_req_   = 1'b1;
          state_nx_s = IDLE;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus_grnt_ == 1'b0) begin
          state_nx_s = ACCESS;
        end else begin
          state_nx_s = REQ;
        end
      end
      ACCESS: begin
        if (bus_rdy_ == 1'b0) begin
          busy       = 1'b0;
          rd_data    = bus_rd_data;
          state_nx_s = stall ? WAIT : IDLE;
        end else begin
          busy       = 1'b1;
          state_nx_s = ACCESS;
        end
      end
      WAIT: begin
        if (stall == 1'b0) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and the registered bus-side signals and read buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      bus_req_r     <= 1'b1;
      bus_as_r      <= 1'b1;
      bus_rw_r      <= 1'b1;
      bus_addr_r    <= 30'd0;
      bus_wr_data_r <= 32'd0;
      rd_buf_r      <= 32'd0;
    end else begin
      state_r  <= state_nx_s;
      // Strobe defaults high so it can only be low for the cycle after a grant.
      bus_as_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            bus_req_r <= 1'b0;
          end
        end
        REQ: begin
          if (bus_grnt_ == 1'b0) begin
            bus_as_r   <= 1'b0;
            bus_addr_r <= addr;
            bus_rw_r   <= rw;
            if (rw == 1'b0) begin
              bus_wr_data_r <= wr_data;
            end
          end
        end
        ACCESS: begin
          if (bus_rdy_ == 1'b0) begin
            bus_req_r <= 1'b1;
            if (bus_rw_r == 1'b1) begin
              rd_buf_r <= bus_rd_data;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Directed testbench for bus_if: reads, delayed-grant write with wait states,
// stall at completion, flush, reset mid-access and back-to-back reads.
module tb_bus_if;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy, as_, rw;
  logic [29:0] addr, bus_addr;
  logic [31:0] wr_data, rd_data, bus_wr_data, bus_rd_data;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;

  int checks = 0;
  int errors = 0;

  bus_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled mid-cycle, away from the rising edge.
  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
    addr = 30'd0; wr_data = 32'd0; bus_grnt_ = 1'b1; bus_rd_data = 32'd0; bus_rdy_ = 1'b1;
    tick(); tick();
    reset = 1'b0;
    mid();
    check_val("rst_busy",    {31'd0, busy},     32'd0);
    check_val("rst_rd_data", rd_data,           32'h0000_0000);
    check_val("rst_req",     {31'd0, bus_req_}, 32'd1);
    check_val("rst_as",      {31'd0, bus_as_},  32'd1);
    check_val("rst_addr",    {2'd0, bus_addr},  32'd0);
    check_val("rst_rw",      {31'd0, bus_rw},   32'd1);
    check_val("rst_wdata",   bus_wr_data,       32'd0);

    // Zero-wait read
    tick();
    as_ = 1'b0; rw = 1'b1; addr = 30'h0000100;
    mid();
    check_val("rd_idle_busy", {31'd0, busy},     32'd1);
    check_val("rd_idle_req",  {31'd0, bus_req_}, 32'd0);
    tick();
    bus_grnt_ = 1'b0;
    mid();
    check_val("rd_req_busy", {31'd0, busy},     32'd1);
    check_val("rd_req_req",  {31'd0, bus_req_}, 32'd0);
    check_val("rd_req_as",   {31'd0, bus_as_},  32'd1);
    tick();
    bus_grnt_ = 1'b1; as_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
    mid();
    check_val("rd_acc_as",    {31'd0, bus_as_}, 32'd0);
    check_val("rd_acc_addr",  {2'd0, bus_addr}, 32'h0000_0100);
    check_val("rd_acc_rw",    {31'd0, bus_rw},  32'd1);
    check_val("rd_acc_busy",  {31'd0, busy},    32'd0);
    check_val("rd_acc_data",  rd_data,          32'hDEAD_BEEF);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = 32'd0;
    mid();
    check_val("rd_done_as",   {31'd0, bus_as_},  32'd1);
    check_val("rd_done_req",  {31'd0, bus_req_}, 32'd1);
    check_val("rd_done_busy", {31'd0, busy},     32'd0);
    check_val("rd_done_buf",  rd_data,           32'hDEAD_BEEF);

    // Write: grant after two REQ cycles, ready on the 4th ACCESS cycle
    tick();
    as_ = 1'b0; rw = 1'b0; addr = 30'h000002A; wr_data = 32'h1234_5678;
    tick();
    for (int i = 0; i < 2; i++) begin
      mid();
      check_val("wr_req_busy", {31'd0, busy},     32'd1);
      check_val("wr_req_req",  {31'd0, bus_req_}, 32'd0);
      check_val("wr_req_as",   {31'd0, bus_as_},  32'd1);
      tick();
    end
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1; as_ = 1'b1; wr_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_val("wr_acc_as",    {31'd0, bus_as_},  (i == 0) ? 32'd0 : 32'd1);
      check_val("wr_acc_busy",  {31'd0, busy},     32'd1);
      check_val("wr_acc_req",   {31'd0, bus_req_}, 32'd0);
      check_val("wr_acc_wdata", bus_wr_data,       32'h1234_5678);
      check_val("wr_acc_rw",    {31'd0, bus_rw},   32'd0);
      check_val("wr_acc_addr",  {2'd0, bus_addr},  32'h0000_002A);
      tick();
    end
    bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFF_0000;
    mid();
    check_val("wr_rdy_busy",  {31'd0, busy}, 32'd0);
    check_val("wr_rdy_wdata", bus_wr_data,   32'h1234_5678);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = 32'd0;
    mid();
    check_val("wr_buf_kept", rd_data,           32'hDEAD_BEEF);
    check_val("wr_done_req", {31'd0, bus_req_}, 32'd1);

    // Read completing under stall, as_ held low throughout
    tick();
    as_ = 1'b0; rw = 1'b1; addr = 30'h0000003;
    tick();
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_A5A5; stall = 1'b1;
    mid();
    check_val("st_acc_busy", {31'd0, busy}, 32'd0);
    check_val("st_acc_data", rd_data,       32'hA5A5_A5A5);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_val("st_wait_busy", {31'd0, busy},     32'd0);
      check_val("st_wait_data", rd_data,           32'hA5A5_A5A5);
      check_val("st_wait_req",  {31'd0, bus_req_}, 32'd1);
      tick();
    end
    stall = 1'b0;
    mid();
    check_val("st_rel_req", {31'd0, bus_req_}, 32'd1);
    tick();
    mid();
    check_val("st_idle_req",  {31'd0, bus_req_}, 32'd0);
    check_val("st_idle_busy", {31'd0, busy},     32'd1);
    as_ = 1'b1;

    // Flush in IDLE blocks a new access
    tick();
    as_ = 1'b0; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      check_val("fl_req",  {31'd0, bus_req_}, 32'd1);
      check_val("fl_busy", {31'd0, busy},     32'd0);
      check_val("fl_data", rd_data,           32'hA5A5_A5A5);
      tick();
    end
    flush = 1'b0; as_ = 1'b1;

    // Reset while waiting on ready
    tick();
    as_ = 1'b0; rw = 1'b1; addr = 30'h0000055;
    tick();
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1; as_ = 1'b1;
    mid();
    check_val("rs_acc_busy", {31'd0, busy},    32'd1);
    check_val("rs_acc_addr", {2'd0, bus_addr}, 32'h0000_0055);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mid();
    check_val("rs_req",  {31'd0, bus_req_}, 32'd1);
    check_val("rs_as",   {31'd0, bus_as_},  32'd1);
    check_val("rs_addr", {2'd0, bus_addr},  32'd0);
    check_val("rs_data", rd_data,           32'd0);
    check_val("rs_busy", {31'd0, busy},     32'd0);

    // Back-to-back reads
    tick();
    as_ = 1'b0; rw = 1'b1; addr = 30'h0000010;
    tick();
    bus_grnt_ = 1'b0;
    tick();
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h1111_1111; addr = 30'h0000020;
    mid();
    check_val("bb1_data", rd_data, 32'h1111_1111);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    mid();
    check_val("bb_idle_busy", {31'd0, busy},     32'd1);
    check_val("bb_idle_req",  {31'd0, bus_req_}, 32'd0);
    tick();
    bus_grnt_ = 1'b0;
    mid();
    check_val("bb_req_busy", {31'd0, busy}, 32'd1);
    tick();
    bus_grnt_ = 1'b1; as_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'h2222_2222;
    mid();
    check_val("bb2_as",   {31'd0, bus_as_}, 32'd0);
    check_val("bb2_addr", {2'd0, bus_addr}, 32'h0000_0020);
    tick();
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    mid();
    check_val("bb2_buf",  rd_data,       32'h2222_2222);
    check_val("bb2_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
